// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: grants the single memory port to one of I-refill, D-refill or D-store at a time.
// Stores have fixed priority over reads; the two read sources alternate round-robin.
module cache_mem_arbiter #(
   parameter int Width_Data  = 32,
   parameter int NUMBER_WORD = 4,
   parameter int Width_ADD   = 32
) (
   input  logic                              CLK,
   input  logic                              RST,
   input  logic                              I_RD_EN_MEM,
   input  logic [Width_ADD-1:0]              I_ADD,
   output logic                              I_RD_Valid_MEM,
   output logic [Width_Data*NUMBER_WORD-1:0] I_Data_RD_MEM,
   input  logic                              D_RD_EN_MEM,
   input  logic [Width_ADD-1:0]              D_ADD,
   input  logic                              D_WR_EN_MEM,
   input  logic [Width_ADD-1:0]              D_Write_ADD_MEM,
   input  logic [Width_Data-1:0]             D_Write_Data_MEM,
   output logic                              D_RD_Valid_MEM,
   output logic [Width_Data*NUMBER_WORD-1:0] D_Data_RD_MEM,
   output logic                              D_Write_ready_MEM,
   output logic                              MEM_RD_EN,
   output logic                              MEM_WR_EN,
   output logic [Width_ADD-1:0]              MEM_ADD,
   output logic [Width_Data-1:0]             MEM_WR_DATA,
   input  logic [Width_Data*NUMBER_WORD-1:0] MEM_RD_DATA,
   input  logic                              MEM_RD_Valid,
   input  logic                              MEM_WR_Ready
);
   localparam int OFF = $clog2(NUMBER_WORD * Width_Data / 8);
   localparam logic [Width_ADD-1:0] ALIGN = {Width_ADD{1'b1}} << OFF;

   typedef enum logic [2:0] {IDLE, GNT_IR, GNT_DR, GNT_DW, DONE} state_t;

   state_t                  state_q, state_d;
   logic                    rr_q, rr_d;
   logic [Width_ADD-1:0]    add_q, add_d;
   logic [Width_Data-1:0]   wdata_q, wdata_d;
   logic                    grant;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         rr_q    <= 1'b0;
         add_q   <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         add_q   <= add_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:           state_d = D_WR_EN_MEM ? GNT_DW :
                                   (I_RD_EN_MEM && D_RD_EN_MEM) ? (rr_q ? GNT_IR : GNT_DR) :
                                   D_RD_EN_MEM ? GNT_DR : I_RD_EN_MEM ? GNT_IR : IDLE;
         GNT_IR, GNT_DR: state_d = MEM_RD_Valid ? DONE : state_q;
         GNT_DW:         state_d = MEM_WR_Ready ? DONE : state_q;
         default:        state_d = IDLE;
      endcase
   end

   // Request fields are captured only on the grant edge so later input changes are ignored.
   always_comb begin
      grant   = (state_q == IDLE);
      rr_d    = (grant && state_d == GNT_IR) ? 1'b0 : (grant && state_d == GNT_DR) ? 1'b1 : rr_q;
      add_d   = !grant ? add_q :
                (state_d == GNT_DW) ? D_Write_ADD_MEM :
                (state_d == GNT_IR) ? (I_ADD & ALIGN) :
                (state_d == GNT_DR) ? (D_ADD & ALIGN) : add_q;
      wdata_d = (grant && state_d == GNT_DW) ? D_Write_Data_MEM : wdata_q;
   end

   always_comb begin
      MEM_RD_EN         = (state_q == GNT_IR) || (state_q == GNT_DR);
      MEM_WR_EN         = (state_q == GNT_DW);
      I_RD_Valid_MEM    = (state_q == GNT_IR) && MEM_RD_Valid;
      D_RD_Valid_MEM    = (state_q == GNT_DR) && MEM_RD_Valid;
      D_Write_ready_MEM = (state_q == GNT_DW) && MEM_WR_Ready;
      MEM_ADD           = add_q;
      MEM_WR_DATA       = wdata_q;
      I_Data_RD_MEM     = MEM_RD_DATA;
      D_Data_RD_MEM     = MEM_RD_DATA;
   end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed per-cycle vector table plus hand-written sequences for
// store streaming and asynchronous reset in the middle of a read.
module tb_cache_mem_arbiter;
   localparam logic [127:0] LINE = 128'h01234567_89ABCDEF_CAFEF00D_DEADBEEF;
   localparam logic [31:0]  A5   = 32'hA5A5A5A5;

   logic         clk = 1'b0, rst_n = 1'b0;
   logic         ird = 1'b0, drd = 1'b0, dwr = 1'b0, mrv = 1'b0, mwr = 1'b0;
   logic [31:0]  iadd = '0, dadd = '0, wadd = '0, wdat = '0;
   logic         i_v, d_v, w_rdy, rd_en, wr_en;
   logic [127:0] i_line, d_line;
   logic [31:0]  m_add, m_wd;
   int           n_cmp = 0, n_fail = 0;

   always #5 clk = ~clk;

   cache_mem_arbiter dut (
      .CLK(clk), .RST(rst_n),
      .I_RD_EN_MEM(ird), .I_ADD(iadd), .I_RD_Valid_MEM(i_v), .I_Data_RD_MEM(i_line),
      .D_RD_EN_MEM(drd), .D_ADD(dadd), .D_WR_EN_MEM(dwr), .D_Write_ADD_MEM(wadd),
      .D_Write_Data_MEM(wdat), .D_RD_Valid_MEM(d_v), .D_Data_RD_MEM(d_line),
      .D_Write_ready_MEM(w_rdy), .MEM_RD_EN(rd_en), .MEM_WR_EN(wr_en), .MEM_ADD(m_add),
      .MEM_WR_DATA(m_wd), .MEM_RD_DATA(LINE), .MEM_RD_Valid(mrv), .MEM_WR_Ready(mwr)
   );

   typedef struct {
      logic        rst, ird, drd, dwr, mrv, mwr;
      logic [31:0] iadd, dadd, wadd, wdat;
      logic [4:0]  en;   // {MEM_RD_EN, MEM_WR_EN, I valid, D valid, write ready}
      logic [31:0] add, wd;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic r, i, input logic [31:0] ia, input logic d,
                               input logic [31:0] da, input logic w, input logic [31:0] wa, wdt,
                               input logic rv, wv, input logic [4:0] e, input logic [31:0] a, wdx);
      vec_t v;
      v.rst = r; v.ird = i; v.iadd = ia; v.drd = d; v.dadd = da; v.dwr = w; v.wadd = wa;
      v.wdat = wdt; v.mrv = rv; v.mwr = wv; v.en = e; v.add = a; v.wd = wdx;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      n_cmp++;
      if (rd_en && wr_en) begin
         n_fail++;
         $display("FAIL mutex: MEM_RD_EN and MEM_WR_EN both high at %0t", $time);
      end
   end

   initial begin
      logic got;
      // reset, single I refill with 3-cycle memory latency, stray valid in IDLE
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,5'b00000,32'h0,0));
      tbl.push_back(mk(1,1,32'h1238,0,0,0,0,0,0,0,5'b00000,32'h0,0));
      tbl.push_back(mk(1,1,32'h1238,0,0,0,0,0,0,0,5'b10000,32'h1230,0));
      tbl.push_back(mk(1,1,32'h1238,0,0,0,0,0,0,0,5'b10000,32'h1230,0));
      tbl.push_back(mk(1,1,32'h1238,0,0,0,0,0,1,0,5'b10100,32'h1230,0));
      tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,5'b00000,32'h1230,0));
      tbl.push_back(mk(1,0,0,0,0,0,0,0,1,1,5'b00000,32'h1230,0));
      // store beats both reads, then D (rr=0, zero-wait), then I
      tbl.push_back(mk(1,1,32'h4448,1,32'h3338,1,32'h2004,A5,0,0,5'b00000,32'h1230,0));
      tbl.push_back(mk(1,1,32'h4448,1,32'h3338,1,32'h2004,A5,0,0,5'b01000,32'h2004,A5));
      tbl.push_back(mk(1,1,32'h4448,1,32'h3338,1,32'h2004,A5,0,1,5'b01001,32'h2004,A5));
      tbl.push_back(mk(1,1,32'h4448,1,32'h3338,0,0,0,0,0,5'b00000,32'h2004,A5));
      tbl.push_back(mk(1,1,32'h4448,1,32'h3338,0,0,0,0,0,5'b00000,32'h2004,A5));
      tbl.push_back(mk(1,1,32'h4448,1,32'h3338,0,0,0,1,0,5'b10010,32'h3330,A5));
      tbl.push_back(mk(1,1,32'h4448,0,0,0,0,0,0,0,5'b00000,32'h3330,A5));
      tbl.push_back(mk(1,1,32'h4448,0,0,0,0,0,0,0,5'b00000,32'h3330,A5));
      tbl.push_back(mk(1,1,32'h4448,0,0,0,0,0,1,0,5'b10100,32'h4440,A5));
      tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,5'b00000,32'h4440,A5));
      // round-robin with both reads held: D, I, D, I
      for (int k = 0; k < 4; k++) begin
         tbl.push_back(mk(1,1,32'h1004,1,32'h200C,0,0,0,0,0,5'b00000,(k==0)?32'h4440:(k[0]?32'h2000:32'h1000),A5));
         tbl.push_back(mk(1,1,32'h1004,1,32'h200C,0,0,0,1,0,k[0]?5'b10100:5'b10010,k[0]?32'h1000:32'h2000,A5));
         tbl.push_back(mk(1,k<3,32'h1004,k<3,32'h200C,0,0,0,0,0,5'b00000,k[0]?32'h1000:32'h2000,A5));
      end
      tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,5'b00000,32'h1000,A5));
      // address stability and ignored write-ready during a read
      tbl.push_back(mk(1,1,32'h5678,0,0,0,0,0,0,0,5'b00000,32'h1000,A5));
      tbl.push_back(mk(1,1,32'h9999,0,0,0,0,0,0,1,5'b10000,32'h5670,A5));
      tbl.push_back(mk(1,1,32'h9999,0,0,0,0,0,1,0,5'b10100,32'h5670,A5));
      tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0,5'b00000,32'h5670,A5));
      tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,5'b00000,32'h5670,A5));
      // reset during GNT_DR, regrant on first edge after release
      tbl.push_back(mk(1,0,0,1,32'h777C,0,0,0,0,0,5'b00000,32'h5670,A5));
      tbl.push_back(mk(1,0,0,1,32'h777C,0,0,0,0,0,5'b10000,32'h7770,A5));
      tbl.push_back(mk(0,0,0,1,32'h777C,0,0,0,0,0,5'b00000,32'h0,0));
      tbl.push_back(mk(1,0,0,1,32'h777C,0,0,0,0,0,5'b00000,32'h0,0));
      tbl.push_back(mk(1,0,0,1,32'h777C,0,0,0,1,0,5'b10010,32'h7770,0));
      tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,5'b00000,32'h7770,0));
      tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,5'b00000,32'h7770,0));

      foreach (tbl[n]) begin
         @(negedge clk);
         rst_n = tbl[n].rst; ird = tbl[n].ird; iadd = tbl[n].iadd; drd = tbl[n].drd;
         dadd = tbl[n].dadd; dwr = tbl[n].dwr; wadd = tbl[n].wadd; wdat = tbl[n].wdat;
         mrv = tbl[n].mrv; mwr = tbl[n].mwr;
         #1;
         chk($sformatf("vec%0d_en", n), {rd_en, wr_en, i_v, d_v, w_rdy}, tbl[n].en);
         chk($sformatf("vec%0d_add", n), m_add, tbl[n].add);
         chk($sformatf("vec%0d_wdata", n), m_wd, tbl[n].wd);
         if (tbl[n].en[2]) chk($sformatf("vec%0d_iline", n), i_line, LINE);
         if (tbl[n].en[1]) chk($sformatf("vec%0d_dline", n), d_line, LINE);
      end

      // streaming stores starve a pending I read
      @(negedge clk);
      ird = 1; iadd = 32'h1111; dwr = 1; wadd = 32'h8000; wdat = 32'h1234;
      repeat (2) begin
         got = 1'b0;
         for (int k = 0; k < 6 && !got; k++) begin @(negedge clk); #1; got = wr_en; end
         chk("stream_wr_grant", got, 1'b1);
         chk("stream_rd_held", rd_en, 1'b0);
         chk("stream_wr_add", {m_add, m_wd}, {32'h8000, 32'h1234});
         mwr = 1; #1;
         chk("stream_wr_ready", w_rdy, 1'b1);
         @(negedge clk); mwr = 0;
      end
      dwr = 0;
      got = 1'b0;
      for (int k = 0; k < 6 && !got; k++) begin @(negedge clk); #1; got = rd_en; end
      chk("starved_rd_grant", got, 1'b1);
      chk("starved_rd_add", m_add, 32'h1110);
      mrv = 1; #1;
      chk("starved_rd_valid", i_v, 1'b1);
      @(negedge clk); mrv = 0; ird = 0;

      // async reset in the middle of a cycle kills enable and pulse at once
      drd = 1; dadd = 32'hABC0;
      got = 1'b0;
      for (int k = 0; k < 6 && !got; k++) begin @(negedge clk); #1; got = rd_en; end
      chk("async_pre_grant", got, 1'b1);
      @(posedge clk); #2;
      mrv = 1; rst_n = 0; #1;
      chk("async_rst_out", {rd_en, wr_en, i_v, d_v, w_rdy}, 5'b00000);
      chk("async_rst_add", m_add, 32'h0);
      mrv = 0; drd = 0;
      @(negedge clk); rst_n = 1;
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares the single main-memory port between instruction-cache line refills, data-cache line refills and data-cache write-through stores. It sits between the cache tops and the memory/bus interface. It grants one transaction at a time and holds it until memory completes. Stores take fixed priority over reads; the two read sources alternate round-robin.

## Interface
- Width_Data, 32, data word width
- NUMBER_WORD, 4, words per cache line (refill is Width_Data*NUMBER_WORD bits)
- Width_ADD, 32, address width

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  reset, asynchronous, active-low
- I_RD_EN_MEM  in  1  I-cache refill request (level, held until served)
- I_ADD  in  Width_ADD  I-cache miss address
- I_RD_Valid_MEM  out  1  one-cycle pulse: I_Data_RD_MEM valid
- I_Data_RD_MEM  out  Width_Data*NUMBER_WORD  refill line to I-cache
- D_RD_EN_MEM  in  1  D-cache refill request (level)
- D_ADD  in  Width_ADD  D-cache miss address
- D_WR_EN_MEM  in  1  D-cache store request (level)
- D_Write_ADD_MEM  in  Width_ADD  store address
- D_Write_Data_MEM  in  Width_Data  store data
- D_RD_Valid_MEM  out  1  one-cycle pulse: D_Data_RD_MEM valid
- D_Data_RD_MEM  out  Width_Data*NUMBER_WORD  refill line to D-cache
- D_Write_ready_MEM  out  1  one-cycle pulse: store accepted by memory
- MEM_RD_EN  out  1  line read request to memory
- MEM_WR_EN  out  1  word write request to memory
- MEM_ADD  out  Width_ADD  memory address
- MEM_WR_DATA  out  Width_Data  memory write data
- MEM_RD_DATA  in  Width_Data*NUMBER_WORD  line from memory
- MEM_RD_Valid  in  1  memory read complete (one cycle)
- MEM_WR_Ready  in  1  memory write complete (one cycle)

## Operation
- States: IDLE, GNT_IR, GNT_DR, GNT_DW, DONE.
- IDLE arbitration:
  - D_WR_EN_MEM high → GNT_DW.
  - Otherwise, if both read requests are high, the `rr` pointer picks the source. `rr`=0 favours D, `rr`=1 favours I.
  - Otherwise, a single read request goes to its state.
  - No request → stay in IDLE.
- On the grant edge, latch the granted request into MEM_ADD and MEM_WR_DATA registers:
  - Read address: aligned, with the low log2(NUMBER_WORD*Width_Data/8) bits (4 for defaults) forced to 0.
  - Store address: passed unmodified.
  - Input changes after the grant are ignored.
- GNT_IR/GNT_DR:
  - MEM_RD_EN=1 until MEM_RD_Valid.
  - On that cycle, pulse the owner's *_RD_Valid_MEM and go to DONE.
  - Granting I sets `rr`=0; granting D read sets `rr`=1.
- GNT_DW:
  - MEM_WR_EN=1 until MEM_WR_Ready.
  - On that cycle, pulse D_Write_ready_MEM and go to DONE.
  - `rr` is unchanged.
- DONE: one turnaround cycle with no grant, so the served cache can drop its request. Always → IDLE.
- I_Data_RD_MEM and D_Data_RD_MEM are both driven combinationally from MEM_RD_DATA; the valid pulse qualifies them.
- Ignored events:
  - MEM_RD_Valid outside GNT_IR/GNT_DR.
  - MEM_WR_Ready outside GNT_DW.
  - Requests arriving in any non-IDLE state (they stay pending).
- MEM_RD_EN and MEM_WR_EN are never high together.

## Timing
- Reset (RST=0, async): state=IDLE, `rr`=0, MEM_RD_EN=MEM_WR_EN=0, MEM_ADD=0, MEM_WR_DATA=0, all valid/ready outputs 0.
- Request sampled in IDLE at edge k → MEM_*_EN high from cycle k+1.
- Memory completion in cycle m → requester pulse in cycle m (combinational) → DONE in m+1 → IDLE in m+2.
- Next grant is possible at the m+2 edge, so back-to-back transactions have a minimum 2-cycle gap between memory enables.
- Zero-wait memory (completion in the first enable cycle) is legal: the enable is high for exactly one cycle.
- Reset asserted mid-transaction: the enable drops immediately and no pulse is produced. The requester must re-request.
- Simultaneous store and reads in IDLE: the store wins and the reads wait. A store re-asserted in IDLE after DONE again beats pending reads; reads can starve while stores stream, which is accepted.

## Test plan
- Single I refill:
  - Stimulus: I_ADD=0x0000_1238, I_RD_EN_MEM=1; memory returns valid 3 cycles later with line 0x…DEADBEEF.
  - Required: MEM_ADD=0x0000_1230; MEM_RD_EN high for exactly those 3 cycles; I_RD_Valid_MEM pulses once with that line; D_RD_Valid_MEM stays 0.
- Store priority:
  - Stimulus: D_WR_EN_MEM, D_RD_EN_MEM and I_RD_EN_MEM all rise together; D_Write_ADD_MEM=0x2004, D_Write_Data_MEM=0xA5A5A5A5.
  - Required: the first grant is a write with MEM_ADD=0x2004 and MEM_WR_DATA=0xA5A5A5A5. D read is granted next (`rr`=0), then I read.
- Round-robin:
  - Stimulus: I and D reads held continuously for 4 transactions.
  - Required: grant order is D, I, D, I, with a DONE cycle between each.
- Stability:
  - Stimulus: change I_ADD during GNT_IR.
  - Required: MEM_ADD is unchanged. A MEM_WR_Ready pulse injected during the read is ignored, and D_Write_ready_MEM stays 0.
- Reset mid-read:
  - Stimulus: RST low during GNT_DR, then release.
  - Required: all outputs 0 immediately and state IDLE. With D still requesting, a fresh grant follows on the first edge after release.
- Zero-wait memory:
  - Stimulus: MEM_RD_Valid high in the same cycle MEM_RD_EN rises.
  - Required: MEM_RD_EN is a 1-cycle pulse and the valid pulse is coincident.
